// File: rtl/ps2_host_tx_if.sv
// Command handshake between the game controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Drives ps2_clk/ps2_data through active-high
// pull-low enables; the open-drain pads live at the top level.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 8        // must be >= 2
) (
  input  logic          clk,
  input  logic          rst,         // asynchronous, active-low
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                     : INHIBIT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  // Line conditioning state; index 0 = ps2_clk, index 1 = ps2_data.
  logic [1:0]            sync1_q, sync2_q;
  logic [FILTER_LEN-1:0] clk_win_q, data_win_q;
  logic [1:0]            filt_q;
  logic                  clk_fall;

  state_e          state_q;
  logic [9:0]      shift_q;
  logic [3:0]      bit_cnt_q;
  logic [CntW-1:0] cnt_q;
  logic            tx_ready_q, busy_q, clk_oe_q, data_oe_q, tx_done_q, tx_err_q;
  logic            timed_state, timeout;

  // Two-flop synchroniser then a FILTER_LEN-sample majority-free glitch filter per line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      clk_win_q  <= '1;
      data_win_q <= '1;
      filt_q     <= '1;
    end else begin
      sync1_q    <= {ps2_data_in, ps2_clk_in};
      sync2_q    <= sync1_q;
      clk_win_q  <= {clk_win_q[FILTER_LEN-2:0], sync2_q[0]};
      data_win_q <= {data_win_q[FILTER_LEN-2:0], sync2_q[1]};
      if (&clk_win_q) begin
        filt_q[0] <= 1'b1;
      end else if (~|clk_win_q) begin
        filt_q[0] <= 1'b0;
      end
      if (&data_win_q) begin
        filt_q[1] <= 1'b1;
      end else if (~|data_win_q) begin
        filt_q[1] <= 1'b0;
      end
    end
  end

  // Event fires in the cycle the filtered clock is about to drop to 0.
  assign clk_fall    = filt_q[0] & ~|clk_win_q;
  assign timed_state = (state_q == StShift) || (state_q == StAck) || (state_q == StWaitIdle);
  assign timeout     = timed_state && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Frame sequencer with registered outputs; error exits release both lines at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      if (timeout) begin
        state_q   <= StIdle;
        busy_q    <= 1'b0;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        tx_err_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            tx_ready_q <= 1'b1;
            if (host.tx_valid && tx_ready_q) begin
              shift_q    <= {1'b1, ~^host.tx_data, host.tx_data};
              cnt_q      <= '0;
              bit_cnt_q  <= '0;
              tx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              clk_oe_q   <= 1'b1;
              state_q    <= StInhibit;
            end
          end
          StInhibit: begin
            if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
              cnt_q     <= '0;
              data_oe_q <= 1'b1;
              state_q   <= StStart;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StStart: begin
            clk_oe_q  <= 1'b0;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
          StShift: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall) begin
              data_oe_q <= ~shift_q[0];
              shift_q   <= {1'b1, shift_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) begin
                state_q <= StAck;
              end
            end
          end
          StAck: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall) begin
              if (bit_cnt_q != 4'd11) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
              if (!filt_q[1]) begin
                state_q <= StWaitIdle;
              end else begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                tx_err_q  <= 1'b1;
              end
            end
          end
          StWaitIdle: begin
            cnt_q <= cnt_q + 1'b1;
            if (filt_q[0] && filt_q[1]) begin
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b0;
              tx_done_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign host.tx_ready = tx_ready_q;
  assign host.busy     = busy_q;
  assign host.tx_done  = tx_done_q;
  assign host.tx_err   = tx_err_q;
  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_data_oe   = data_oe_q;

endmodule
